lopd_norm_seq: RTL and testbench

//   Multi-cycle mantissa normaliser for the FP datapath. Scans a wide mantissa 8 bits at a time

---
 rtl/lopd_norm_seq.sv | 142 ++++++++++++++
 tb/tb_lopd_norm_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lopd_norm_seq.sv
// Multi-cycle mantissa normaliser: scans 8-bit chunks MSB-first through a shared LOPD_8bit, then left-justifies.
// Optional build macro LOPD_NORM_ZERO_BYPASS_EN lets an all-zero mantissa skip the chunk scan.
module lopd_norm_seq #(
    parameter int SIZE_MANT = 32,
    parameter int SIZE_LZC  = $clog2(SIZE_MANT) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_MANT-1:0] i_mant,
    output logic [7:0]           o_lopd_data,
    input  logic [2:0]           i_lopd_pos,
    input  logic                 i_lopd_zero,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_MANT-1:0] o_mant_norm,
    output logic [SIZE_LZC-1:0]  o_lzc,
    output logic                 o_zero_flag
);

    localparam int N_CHUNK = SIZE_MANT / 8;
    localparam int K_W     = $clog2(N_CHUNK);

    localparam logic [K_W-1:0]      K_LAST   = K_W'(N_CHUNK - 1);
    localparam logic [SIZE_LZC-1:0] ACC_STEP = SIZE_LZC'(8);
    localparam logic [SIZE_LZC-1:0] LZC_ALL  = SIZE_LZC'(SIZE_MANT);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [SIZE_MANT-1:0]  mant_reg, mant_next;
    logic [K_W-1:0]        k, k_next;
    logic [SIZE_LZC-1:0]   acc, acc_next;
    logic                  valid_next;
    logic [SIZE_MANT-1:0]  norm_next;
    logic [SIZE_LZC-1:0]   lzc_next;
    logic                  zero_next;
    logic [7:0]            chunks [N_CHUNK];

    // Chunk 0 is the most significant byte of the held mantissa.
    for (genvar g = 0; g < N_CHUNK; g++) begin : g_chunk
        assign chunks[g] = mant_reg[SIZE_MANT-1-8*g -: 8];
    end

    assign o_ready = (state == IDLE) && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            mant_reg    <= '0;
            k           <= '0;
            acc         <= '0;
            o_valid     <= 1'b0;
            o_mant_norm <= '0;
            o_lzc       <= '0;
            o_zero_flag <= 1'b0;
        end else begin
            state       <= state_next;
            mant_reg    <= mant_next;
            k           <= k_next;
            acc         <= acc_next;
            o_valid     <= valid_next;
            o_mant_norm <= norm_next;
            o_lzc       <= lzc_next;
            o_zero_flag <= zero_next;
        end
    end

    // SHIFT treats acc==SIZE_MANT as the zero result, so the bypass path can reuse it
    // and still land in DONE one cycle after the accept edge.
    always_comb begin
        state_next  = state;
        mant_next   = mant_reg;
        k_next      = k;
        acc_next    = acc;
        valid_next  = o_valid;
        norm_next   = o_mant_norm;
        lzc_next    = o_lzc;
        zero_next   = o_zero_flag;
        o_lopd_data = 8'h00;

        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    mant_next  = i_mant;
                    acc_next   = '0;
                    k_next     = '0;
                    state_next = SCAN;
`ifdef LOPD_NORM_ZERO_BYPASS_EN
                    if (!(|i_mant)) begin
                        acc_next   = LZC_ALL;
                        state_next = SHIFT;
                    end
`endif
                end
            end

            SCAN: begin
                o_lopd_data = chunks[k];
                if (i_lopd_zero) begin
                    if (k == K_LAST) begin
                        norm_next  = '0;
                        lzc_next   = LZC_ALL;
                        zero_next  = 1'b1;
                        valid_next = 1'b1;
                        state_next = DONE;
                    end else begin
                        acc_next = acc + ACC_STEP;
                        k_next   = k + K_W'(1);
                    end
                end else begin
                    acc_next   = acc + {{(SIZE_LZC-3){1'b0}}, i_lopd_pos};
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                norm_next  = mant_reg << acc;
                lzc_next   = acc;
                zero_next  = (acc == LZC_ALL);
                valid_next = 1'b1;
                state_next = DONE;
            end

            DONE: begin
                if (i_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lopd_norm_seq.sv
// Directed and random bench for lopd_norm_seq (SIZE_MANT=32) with a combinational LOPD_8bit model.
// Expected zero-input latency follows LOPD_NORM_ZERO_BYPASS_EN.
module tb_lopd_norm_seq;

    localparam int SM = 32;
    localparam int SL = 6;

`ifdef LOPD_NORM_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 4;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [SM-1:0] i_mant;
    logic [7:0]    o_lopd_data;
    logic [2:0]    i_lopd_pos;
    logic          i_lopd_zero;
    logic          o_valid;
    logic          i_ready;
    logic [SM-1:0] o_mant_norm;
    logic [SL-1:0] o_lzc;
    logic          o_zero_flag;

    int total = 0;
    int bad   = 0;
    int lat;
    logic [7:0] lopd_seen [0:63];

    always #5 i_clk = ~i_clk;

    lopd_norm_seq #(.SIZE_MANT(SM), .SIZE_LZC(SL)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mant      (i_mant),
        .o_lopd_data (o_lopd_data),
        .i_lopd_pos  (i_lopd_pos),
        .i_lopd_zero (i_lopd_zero),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_mant_norm (o_mant_norm),
        .o_lzc       (o_lzc),
        .o_zero_flag (o_zero_flag)
    );

    // LOPD_8bit model: position is the distance of the leading one from bit 7.
    assign i_lopd_zero = (o_lopd_data == 8'h00);
    always_comb begin
        i_lopd_pos = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (o_lopd_data[b]) i_lopd_pos = 3'(7 - b);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [SM-1:0] mant, output int latency);
        int waited = 0;
        @(negedge i_clk);
        while (!o_ready && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        i_valid = 1'b1;
        i_mant  = mant;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_mant  = ~mant;
        latency = -1;
        lopd_seen[0] = o_lopd_data;
        for (int c = 1; c <= 40; c++) begin
            @(posedge i_clk);
            #1;
            lopd_seen[c] = o_lopd_data;
            if (o_valid) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [SM-1:0] exp_mant,
                               input logic [SL-1:0] exp_lzc, input logic exp_zero,
                               input int exp_lat, input int got_lat);
        checkEq({tag, "_lat"},   32'(got_lat), 32'(exp_lat));
        checkEq({tag, "_mant"},  o_mant_norm, exp_mant);
        checkEq({tag, "_lzc"},   32'(o_lzc), 32'(exp_lzc));
        checkEq({tag, "_zero"},  32'(o_zero_flag), 32'(exp_zero));
    endtask

    task automatic releaseResult(input string tag);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        checkEq({tag, "_rel_valid"}, 32'(o_valid), 32'd0);
        checkEq({tag, "_rel_ready"}, 32'(o_ready), 32'd1);
    endtask

    function automatic int refLzc(input logic [SM-1:0] m);
        int n = SM;
        for (int i = 0; i < SM; i++) begin
            if (m[i]) n = SM - 1 - i;
        end
        return n;
    endfunction

    initial begin
        logic [SM-1:0] m;
        logic [SM-1:0] exp_m;
        int            exp_l;
        bit            saw_valid;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_mant  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checkEq("rst_valid", 32'(o_valid), 32'd0);
        checkEq("rst_mant",  o_mant_norm, 32'd0);
        checkEq("rst_lzc",   32'(o_lzc), 32'd0);
        checkEq("rst_zero",  32'(o_zero_flag), 32'd0);
        checkEq("rst_ready", 32'(o_ready), 32'd0);
        checkEq("rst_lopd",  32'(o_lopd_data), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkEq("rst_rel_ready", 32'(o_ready), 32'd1);

        applyStimulus(32'h8000_0000, lat);
        checkOutput("msb", 32'h8000_0000, 6'd0, 1'b0, 2, lat);
        releaseResult("msb");

        applyStimulus(32'h0012_3456, lat);
        checkEq("c2_lopd0", 32'(lopd_seen[0]), 32'h00);
        checkEq("c2_lopd1", 32'(lopd_seen[1]), 32'h12);
        checkEq("c2_lopd2", 32'(lopd_seen[2]), 32'h00);
        checkOutput("c2", 32'h91A2_B000, 6'd11, 1'b0, 3, lat);
        releaseResult("c2");

        applyStimulus(32'h0000_0001, lat);
        checkOutput("lsb", 32'h8000_0000, 6'd31, 1'b0, 5, lat);
        releaseResult("lsb");

        applyStimulus(32'h0000_0000, lat);
        checkOutput("zero", 32'h0000_0000, 6'd32, 1'b1, ZERO_LAT, lat);
        releaseResult("zero");

        applyStimulus(32'h0000_8000, lat);
        checkOutput("c16", 32'h8000_0000, 6'd16, 1'b0, 4, lat);
        releaseResult("c16");

        applyStimulus(32'hFFFF_FFFF, lat);
        checkOutput("ones", 32'hFFFF_FFFF, 6'd0, 1'b0, 2, lat);
        releaseResult("ones");

        // Backpressure: result must hold while downstream stalls; an input pulse is ignored.
        applyStimulus(32'h0012_3456, lat);
        checkOutput("bp", 32'h91A2_B000, 6'd11, 1'b0, 3, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_valid = (c == 2);
            i_mant  = 32'hDEAD_BEEF;
            @(posedge i_clk);
            #1;
            checkEq($sformatf("bp%0d_valid", c), 32'(o_valid), 32'd1);
            checkEq($sformatf("bp%0d_mant", c),  o_mant_norm, 32'h91A2_B000);
            checkEq($sformatf("bp%0d_lzc", c),   32'(o_lzc), 32'd11);
            checkEq($sformatf("bp%0d_ready", c), 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        releaseResult("bp");
        @(posedge i_clk);
        #1;
        checkEq("bp_no_queue", 32'(o_valid), 32'd0);

        // Reset mid-scan drops the transaction.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_mant  = 32'h0000_00FF;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        checkEq("mrst_ready_low", 32'(o_ready), 32'd0);
        checkEq("mrst_valid",     32'(o_valid), 32'd0);
        checkEq("mrst_lopd",      32'(o_lopd_data), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkEq("mrst_ready", 32'(o_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge i_clk);
            #1;
            if (o_valid) saw_valid = 1'b1;
        end
        checkEq("mrst_dropped", 32'(saw_valid), 32'd0);
        applyStimulus(32'h0100_0000, lat);
        checkOutput("after_rst", 32'h8000_0000, 6'd7, 1'b0, 2, lat);
        releaseResult("after_rst");

        for (int i = 0; i < 1000; i++) begin
            m     = $urandom() >> $urandom_range(0, 32);
            exp_l = refLzc(m);
            exp_m = (exp_l == SM) ? '0 : (m << exp_l);
            applyStimulus(m, lat);
            checkOutput($sformatf("rnd%0d", i), exp_m, SL'(exp_l), (exp_l == SM),
                        (exp_l == SM) ? ZERO_LAT : (exp_l / 8 + 2), lat);
            releaseResult($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
